eco32f_div_seq: RTL
===================

ECO32F_DIV_SEQ -- requirements
Module: eco32f_div_seq

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ex_op_div  input  1  execute-stage instruction is div/divi/divu/divui.
REQ-005 ex_op_rem  input  1  execute-stage instruction is rem/remi/remu/remui.
REQ-006 ex_signed_div  input  1  signed operation when 1, unsigned when 0.
REQ-007 ex_flush  input  1  pipeline flush; aborts any operation in flight.
REQ-008 div_op_a  input  32  dividend (x operand).
REQ-009 div_op_b  input  32  divisor (y operand or immediate).
REQ-010 div_stall  output  1  stall request to the pipeline.
REQ-011 div_done  output  1  one-cycle pulse; div_result valid.
REQ-012 div_result  output  32  quotient (div) or remainder (rem).
REQ-013 div_exc_zero  output  1  one-cycle pulse with div_done; divisor was zero.

Function
REQ-014 The block SHALL define req = (ex_op_div | ex_op_rem) & !ex_flush.
REQ-015 The FSM SHALL have states IDLE, CALC, FIXUP and DONE.
REQ-016 IDLE: req at an edge -> latch operands, op kind and sign mode; go to CALC with a 5-bit count of 0. If div_op_b == 0, go to DONE with the zero flag set.
REQ-017 Latch values SHALL be the operand magnitudes when signed (two's-complement negate if bit 31 set), raw values when unsigned.
REQ-018 CALC: one restoring-division step per cycle, MSB first (shift partial remainder, trial subtract, set quotient bit); exactly 32 cycles, count wraps 31 -> FIXUP.
REQ-019 FIXUP, signed: negate quotient if the operand signs differed; negate remainder if the dividend was negative. Unsigned: no change. Next state DONE.
REQ-020 DONE: div_done = 1 for exactly one cycle; unconditional return to IDLE on the next edge.
REQ-021 Latency: start edge E0, CALC edges E1..E32, FIXUP at E33; div_done high in the cycle after E33.
REQ-022 Divide-by-zero latency: div_done and div_exc_zero are high in the cycle after the start edge, with div_result = 0.
REQ-023 div_stall SHALL be asserted when (req & state != DONE), or when state is CALC or FIXUP, and deasserted otherwise.
REQ-024 Operand input changes after the start edge SHALL have no effect on the result.
REQ-025 Signed -2^31 / -1 SHALL give quotient 0x80000000 and remainder 0 (32-bit wrap), with no exception.
REQ-026 All arithmetic SHALL be truncated to 32 bits; remainder magnitude < divisor magnitude.
REQ-027 ex_flush in CALC, FIXUP or DONE -> IDLE on the next edge, with no div_done or div_exc_zero pulse.
REQ-028 ex_flush concurrent with a request in IDLE -> no start.
REQ-029 In DONE, a new request SHALL NOT start; it is sampled from IDLE on the following cycle (back-to-back ops cost one extra cycle).
REQ-030 div_result SHALL hold its last value outside DONE.
REQ-031 div_done and div_exc_zero SHALL be registered outputs, glitch-free.

Reset
REQ-032 rst low SHALL, asynchronously: state = IDLE, count = 0, div_done = 0, div_exc_zero = 0, div_result = 0, all latched operands = 0.
REQ-033 div_stall SHALL be 0 while in reset, regardless of inputs.
REQ-034 Reset deassertion mid-operation SHALL resume from IDLE; the aborted operation is not resumed.

Verification
REQ-035 divu: 100 / 7 -> div_result 14, div_done in the cycle after E33, div_stall high in cycles E0..E33.
REQ-036 rem signed: -7 rem 2 -> 0xFFFFFFFF; div signed: -7 / 2 -> 0xFFFFFFFD; remu: 0xFFFFFFFF rem 0x10 -> 0xF.
REQ-037 div signed: 0x12345678 / 0 -> div_exc_zero and div_done in the cycle after E0, div_result 0.
REQ-038 div signed: 0x80000000 / 0xFFFFFFFF -> 0x80000000, div_exc_zero 0.
REQ-039 ex_flush asserted at CALC count 10 -> IDLE next cycle, div_stall 0, no div_done; rst pulsed at count 20 of a new op -> all outputs 0.
REQ-040 Two back-to-back divu ops (50/5 then 9/4) -> results 10 then 2, second div_done 35 cycles after the first.

Source files
------------

// File: rtl/eco32f_div_seq.sv
// Sequential 32-bit integer divider for the ECO32F execute stage.
// It handles div/divu/rem/remu with one restoring-division step per cycle
// and stalls the pipeline while an operation is in flight.
module eco32f_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_op_div,
    input  logic        ex_op_rem,
    input  logic        ex_signed_div,
    input  logic        ex_flush,
    input  logic [31:0] div_op_a,
    input  logic [31:0] div_op_b,
    output logic        div_stall,
    output logic        div_done,
    output logic [31:0] div_result,
    output logic        div_exc_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic        op_rem;
    logic        neg_quo;
    logic        neg_rem;

    logic        req;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] trial_shift;
    logic [32:0] trial_diff;
    logic [31:0] fix_quo;
    logic [31:0] fix_rem;

    // A flushed instruction never counts as a request.
    assign req = (ex_op_div | ex_op_rem) & ~ex_flush;

    // Signed operations divide magnitudes; signs are reapplied in FIXUP.
    assign mag_a = (ex_signed_div & div_op_a[31]) ? (~div_op_a + 32'd1) : div_op_a;
    assign mag_b = (ex_signed_div & div_op_b[31]) ? (~div_op_b + 32'd1) : div_op_b;

    // Restoring step: shift the next dividend bit into the partial
    // remainder, then trial-subtract the divisor; bit 32 is the borrow.
    assign trial_shift = {rem, quo[31]};
    assign trial_diff  = trial_shift - {1'b0, dvsr};

    // Sign correction of the unsigned quotient and remainder.
    assign fix_quo = neg_quo ? (~quo + 32'd1) : quo;
    assign fix_rem = neg_rem ? (~rem + 32'd1) : rem;

    // Hold the pipeline from the requesting cycle until the result is ready;
    // forced low while reset is asserted.
    assign div_stall = rst & ((req & (state != DONE)) | (state == CALC) | (state == FIXUP));

    // Division FSM with registered result and done/exception pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= 5'd0;
            quo          <= 32'd0;
            rem          <= 32'd0;
            dvsr         <= 32'd0;
            op_rem       <= 1'b0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            div_done     <= 1'b0;
            div_exc_zero <= 1'b0;
            div_result   <= 32'd0;
        end else begin
            div_done     <= 1'b0;
            div_exc_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_rem  <= ex_op_rem;
                        neg_quo <= ex_signed_div & (div_op_a[31] ^ div_op_b[31]);
                        neg_rem <= ex_signed_div & div_op_a[31];
                        quo     <= mag_a;
                        rem     <= 32'd0;
                        dvsr    <= mag_b;
                        count   <= 5'd0;
                        if (div_op_b == 32'd0) begin
                            state        <= DONE;
                            div_done     <= 1'b1;
                            div_exc_zero <= 1'b1;
                            div_result   <= 32'd0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (ex_flush) begin
                        state <= IDLE;
                        count <= 5'd0;
                    end else begin
                        if (!trial_diff[32]) begin
                            rem <= trial_diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= trial_shift[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    if (ex_flush) begin
                        state <= IDLE;
                    end else begin
                        quo        <= fix_quo;
                        rem        <= fix_rem;
                        div_result <= op_rem ? fix_rem : fix_quo;
                        div_done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
